// File: rtl/div_iter_param.sv
// Iterative restoring integer divider (signed/unsigned), BITS_PER_CYCLE quotient bits per clock.
// Produces {remainder, quotient} and holds it until start_i is dropped.
module div_iter_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 div_by_zero_o,
  output logic                 div_stall
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [2:0] {S_IDLE, S_ON, S_FIX, S_ZERO, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dq;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign1;
  logic               r_sign2;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dbz;
  logic               r_stall;

  logic               w_clear;
  logic               w_accept;
  logic               w_last;
  logic               w_op2_zero;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_emit;

  assign w_clear    = !rst || flush;
  assign w_accept   = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_last     = (r_cnt == CW'(ITER - 1));
  assign w_op2_zero = (opdata2_i == '0);
  assign w_neg1     = signed_div_i && opdata1_i[WIDTH-1];
  assign w_neg2     = signed_div_i && opdata2_i[WIDTH-1];
  assign w_mag1     = w_neg1 ? -opdata1_i : opdata1_i;
  assign w_mag2     = w_neg2 ? -opdata2_i : opdata2_i;
  assign w_emit     = (r_state == S_DONE) && start_i;

  // r_dq starts as the dividend magnitude; each step shifts its MSB into the
  // partial remainder and a quotient bit into its LSB, so it ends as the quotient.
  logic [WIDTH-1:0] w_rem [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] w_dq  [BITS_PER_CYCLE+1];

  assign w_rem[0] = r_rem;
  assign w_dq[0]  = r_dq;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [WIDTH:0] w_shift;
    logic           w_ge;
    assign w_shift       = {w_rem[gi], w_dq[gi][WIDTH-1]};
    assign w_ge          = (w_shift >= {1'b0, r_divisor});
    assign w_rem[gi+1]   = w_ge ? (w_shift[WIDTH-1:0] - r_divisor) : w_shift[WIDTH-1:0];
    assign w_dq[gi+1]    = {w_dq[gi][WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (w_clear) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_op2_zero ? S_ZERO : S_ON;
      S_ON: begin
        if (annul_i)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_FIX;
      end
      S_FIX:  w_state_next = S_DONE;
      S_ZERO: w_state_next = S_DONE;
      S_DONE: if (!start_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dq      <= '0;
      r_divisor <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_zero    <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_dbz     <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      // Outputs are registered from DONE so they are only ever non-zero while valid.
      r_ready  <= w_emit;
      r_result <= w_emit ? {r_rem, r_dq} : '0;
      r_dbz    <= w_emit && r_zero;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign1   <= w_neg1;
            r_sign2   <= w_neg2;
            r_divisor <= w_mag2;
            // A zero divisor keeps the raw dividend for the {op1, all-ones} result.
            r_dq      <= w_op2_zero ? opdata1_i : w_mag1;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_zero    <= w_op2_zero;
            r_stall   <= 1'b1;
          end else begin
            r_stall   <= 1'b0;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_stall <= 1'b0;
          end else begin
            r_rem <= w_rem[BITS_PER_CYCLE];
            r_dq  <= w_dq[BITS_PER_CYCLE];
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (r_sign1 ^ r_sign2) r_dq  <= -r_dq;
          if (r_sign1)           r_rem <= -r_rem;
        end
        S_ZERO: begin
          r_rem <= r_dq;
          r_dq  <= '1;
        end
        S_DONE:  r_stall <= 1'b0;
        default: r_stall <= 1'b0;
      endcase
    end
  end

  assign result_o      = r_result;
  assign ready_o       = r_ready;
  assign div_by_zero_o = r_dbz;
  assign div_stall     = r_stall;

endmodule
